// File: rtl/auto_parkcalc_hls_deadlock_ctrl.sv
// -----------------------------------------------------------------------------
// auto_parkcalc_hls_deadlock_ctrl
//
// Deadlock controller for the auto_parkcalc HLS core. It collects the per-
// instance block flags of the deadlock monitors and requires `any` block to
// persist for THRESH consecutive enabled cycles before it confirms a deadlock.
// On confirmation it latches the set of blocked monitors and reports their
// indices, lowest first, one per handshake on a valid/ready channel. It then
// holds the deadlock flag in HALT until `clear` releases it.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-low reset
//   enable        arms detection
//   block_in      monitor block flags, bit i from monitor i
//   clear         single-cycle release of a latched deadlock (highest priority)
//   deadlock      confirmed-deadlock flag
//   report_valid  a report index is presented
//   report_idx    index of a blocked monitor (lowest pending bit)
//   report_last   the presented index is the final one
//   report_ready  consumer accepts the current index
//   event_cnt     saturating count of confirmed deadlocks
//
// All outputs decode from registers only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module auto_parkcalc_hls_deadlock_ctrl #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] block_in,
  input  logic               clear,
  output logic               deadlock,
  output logic               report_valid,
  output logic [IDX_W-1:0]   report_idx,
  output logic               report_last,
  input  logic               report_ready,
  output logic [7:0]         event_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SUSPECT = 2'd1;
  localparam logic [1:0] S_REPORT  = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  logic [1:0]         state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [NUM_MON-1:0] pending_q,   pending_d;
  logic [7:0]         event_cnt_q, event_cnt_d;

  logic               any_block;
  logic [NUM_MON-1:0] lowest_bit;
  logic [IDX_W-1:0]   lowest_idx;
  logic               one_left;
  logic               handshake;

  assign any_block = |block_in;

  // Two's-complement trick isolates the lowest set bit of pending.
  assign lowest_bit = pending_q & (~pending_q + NUM_MON'(1));
  // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
  assign one_left   = (pending_q != '0) && ((pending_q & (pending_q - NUM_MON'(1))) == '0);

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  // Output decode, from registers only.
  assign report_valid = (state_q == S_REPORT);
  assign deadlock     = (state_q == S_REPORT) || (state_q == S_HALT);
  assign report_idx   = report_valid ? lowest_idx : '0;
  assign report_last  = report_valid & one_left;
  assign event_cnt    = event_cnt_q;

  assign handshake = report_valid & report_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    event_cnt_d = event_cnt_q;

    if (clear) begin
      // Clear wins over everything, including a handshake in REPORT.
      state_d   = S_IDLE;
      cnt_d     = '0;
      pending_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable && any_block) begin
            state_d = S_SUSPECT;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        S_SUSPECT: begin
          if (!enable || !any_block) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = S_REPORT;
            pending_d = block_in;
            if (event_cnt_q != 8'hFF) event_cnt_d = event_cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REPORT: begin
          if (handshake) begin
            pending_d = pending_q & ~lowest_bit;
            if (one_left) state_d = S_HALT;
          end
        end
        default: begin
          // HALT: hold until clear.
          state_d = S_HALT;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: pending is a small flag vector, not a memory, so it is reset
      // along with the rest; report_idx/report_last decode to 0 from it.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      event_cnt_q <= event_cnt_d;
    end
  end

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for auto_parkcalc_hls_deadlock_ctrl (default parameters).
// Table-driven: each record holds the inputs applied for `reps` clock edges
// and the outputs expected after the last of those edges. Hand-written
// sequences cover event counter saturation and reset asserted mid-REPORT.
// -----------------------------------------------------------------------------
module tb_auto_parkcalc_hls_deadlock_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] block_in;
  logic       clear;
  logic       deadlock;
  logic       report_valid;
  logic [1:0] report_idx;
  logic       report_last;
  logic       report_ready;
  logic [7:0] event_cnt;

  int checks   = 0;
  int failures = 0;

  auto_parkcalc_hls_deadlock_ctrl #(
    .NUM_MON(4), .IDX_W(2), .THRESH(16), .CNT_W(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .block_in     (block_in),
    .clear        (clear),
    .deadlock     (deadlock),
    .report_valid (report_valid),
    .report_idx   (report_idx),
    .report_last  (report_last),
    .report_ready (report_ready),
    .event_cnt    (event_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en;
    logic [3:0] blk;
    logic       clr;
    logic       rdy;
    int         reps;
    logic       dl;
    logic       vld;
    logic [1:0] idx;
    logic       last;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic dl, input logic vld,
                           input logic [1:0] idx, input logic last, input logic [7:0] ec);
    check({tag, ".deadlock"},     8'(deadlock),     8'(dl));
    check({tag, ".report_valid"}, 8'(report_valid), 8'(vld));
    check({tag, ".report_idx"},   8'(report_idx),   8'(idx));
    check({tag, ".report_last"},  8'(report_last),  8'(last));
    check({tag, ".event_cnt"},    event_cnt,        ec);
  endtask

  // Apply inputs for n edges; inputs change #1 after an edge.
  task automatic run(input logic en, input logic [3:0] blk, input logic clr,
                     input logic rdy, input int n);
    enable = en; block_in = blk; clear = clr; report_ready = rdy;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic vec_t v(input logic en, input logic [3:0] blk, input logic clr,
                             input logic rdy, input int reps, input logic dl,
                             input logic vld, input logic [1:0] idx, input logic last,
                             input logic [7:0] ec);
    vec_t r;
    r.en = en; r.blk = blk; r.clr = clr; r.rdy = rdy; r.reps = reps;
    r.dl = dl; r.vld = vld; r.idx = idx; r.last = last; r.ec = ec;
    return r;
  endfunction

  initial begin
    //             en  blk    clr rdy reps dl vld idx  last ec
    // Clear held with enable&any must not arm; count starts after release.
    vecs.push_back(v(1, 4'hF, 1, 0, 3,   0, 0, 2'd0, 0, 8'd0));
    vecs.push_back(v(1, 4'hF, 0, 0, 15,  0, 0, 2'd0, 0, 8'd0));
    vecs.push_back(v(1, 4'h2, 0, 0, 1,   1, 1, 2'd1, 1, 8'd1));
    vecs.push_back(v(0, 4'h0, 1, 0, 1,   0, 0, 2'd0, 0, 8'd1));
    // Threshold: block_in=0010 for 16 edges, ready high.
    vecs.push_back(v(1, 4'h2, 0, 1, 15,  0, 0, 2'd0, 0, 8'd1));
    vecs.push_back(v(1, 4'h2, 0, 1, 1,   1, 1, 2'd1, 1, 8'd2));
    vecs.push_back(v(1, 4'h2, 0, 1, 1,   1, 0, 2'd0, 0, 8'd2));
    vecs.push_back(v(0, 4'h0, 0, 1, 3,   1, 0, 2'd0, 0, 8'd2));
    vecs.push_back(v(0, 4'h0, 1, 0, 1,   0, 0, 2'd0, 0, 8'd2));
    // Glitch restart: 10 high, 1 low, 15 high -> none; one more -> confirm.
    vecs.push_back(v(1, 4'hF, 0, 0, 10,  0, 0, 2'd0, 0, 8'd2));
    vecs.push_back(v(1, 4'h0, 0, 0, 1,   0, 0, 2'd0, 0, 8'd2));
    vecs.push_back(v(1, 4'h4, 0, 0, 15,  0, 0, 2'd0, 0, 8'd2));
    vecs.push_back(v(1, 4'h8, 0, 0, 1,   1, 1, 2'd3, 1, 8'd3));
    vecs.push_back(v(1, 4'h8, 0, 0, 2,   1, 1, 2'd3, 1, 8'd3));
    vecs.push_back(v(0, 4'h0, 1, 0, 1,   0, 0, 2'd0, 0, 8'd3));
    // Multi-index 1011 with ready 1,0,1,0,1; block_in/enable ignored in REPORT.
    vecs.push_back(v(1, 4'hB, 0, 0, 16,  1, 1, 2'd0, 0, 8'd4));
    vecs.push_back(v(0, 4'h0, 0, 1, 1,   1, 1, 2'd1, 0, 8'd4));
    vecs.push_back(v(0, 4'h4, 0, 0, 1,   1, 1, 2'd1, 0, 8'd4));
    vecs.push_back(v(1, 4'h0, 0, 1, 1,   1, 1, 2'd3, 1, 8'd4));
    vecs.push_back(v(0, 4'hF, 0, 0, 1,   1, 1, 2'd3, 1, 8'd4));
    vecs.push_back(v(0, 4'h0, 0, 1, 1,   1, 0, 2'd0, 0, 8'd4));
    vecs.push_back(v(0, 4'h0, 1, 0, 1,   0, 0, 2'd0, 0, 8'd4));
    // Enable gating: 100 cycles blocked but disabled, then 16 enabled.
    vecs.push_back(v(0, 4'hF, 0, 0, 100, 0, 0, 2'd0, 0, 8'd4));
    vecs.push_back(v(1, 4'hF, 0, 0, 15,  0, 0, 2'd0, 0, 8'd4));
    vecs.push_back(v(1, 4'hF, 0, 0, 1,   1, 1, 2'd0, 0, 8'd5));
    // Clear together with the first handshake: clear wins.
    vecs.push_back(v(1, 4'hF, 1, 1, 1,   0, 0, 2'd0, 0, 8'd5));
    // Re-block right after the clear edge confirms 16 edges later.
    vecs.push_back(v(1, 4'h6, 0, 0, 15,  0, 0, 2'd0, 0, 8'd5));
    vecs.push_back(v(1, 4'h6, 0, 0, 1,   1, 1, 2'd1, 0, 8'd6));

    reset = 1'b0; enable = 1'b0; block_in = '0; clear = 1'b0; report_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset_hold", 0, 0, 2'd0, 0, 8'd0);
    reset = 1'b1;
    run(0, 4'h0, 0, 0, 2);
    check_all("post_reset", 0, 0, 2'd0, 0, 8'd0);

    foreach (vecs[i]) begin
      run(vecs[i].en, vecs[i].blk, vecs[i].clr, vecs[i].rdy, vecs[i].reps);
      check_all($sformatf("vec%0d", i), vecs[i].dl, vecs[i].vld, vecs[i].idx,
                vecs[i].last, vecs[i].ec);
    end

    // Saturation: 260 more confirmations from event_cnt=6 must stop at 255.
    for (int k = 0; k < 260; k++) begin
      run(0, 4'h0, 1, 0, 1);
      run(1, 4'h1, 0, 0, 16);
    end
    check_all("saturate", 1, 1, 2'd0, 1, 8'd255);

    // Reset asserted mid-REPORT, away from a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 2'd0, 0, 8'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    run(0, 4'hF, 0, 1, 3);
    check_all("after_reset_idle", 0, 0, 2'd0, 0, 8'd0);
    // State must be IDLE: a fresh detection needs the full 16 edges.
    run(1, 4'hF, 0, 0, 15);
    check_all("after_reset_15", 0, 0, 2'd0, 0, 8'd0);
    run(1, 4'hF, 0, 0, 1);
    check_all("after_reset_16", 1, 1, 2'd0, 0, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
